// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer state encoding, default
// start-of-frame marker and the clocks-per-bit helper used by the
// receiver, transmitter and frame sequencer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } frame_state_t;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // Integer clocks per bit; the fractional remainder is dropped.
    function automatic int unsigned calc_cpb(input int unsigned base_freq,
                                             input int unsigned baudrate);
        return base_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the frame sequencer.
// clr restarts the count, run enables counting (held at zero otherwise),
// expired is asserted in the cycle the count reaches TIMEOUT_BITS*CPB-1.
module uart_frame_timeout #(
    parameter int unsigned CPB          = 434,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [31:0] LIMIT = 32'(CPB * TIMEOUT_BITS) - 32'd1;

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: restart on a new byte or when not in a receiving state.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (clr_i || !run_i) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A strobe in the same cycle wins over expiry.
    assign expired_o = run_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame sequencer behind uart_rx: SOF, CMD, LEN, payload, CHK (XOR of
// CMD, LEN and payload). Good frames are held on a valid/ready interface;
// checksum, length, timeout and overrun errors are 1-cycle pulses.
// Optional build macro UART_FRAME_STATS_EN adds saturating frm_count_o and
// err_count_o outputs.
//
//  state   | meaning
//  IDLE    | waiting for the SOF byte, other bytes ignored
//  CMD     | next byte is the command
//  LEN     | next byte is the payload length
//  PAYLOAD | collecting payload bytes
//  CHK     | next byte is the checksum
//  HOLD    | frame presented, waiting for frm_ready_i
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned BASE_FREQ    = 50_000_000,
    parameter int unsigned BAUDRATE     = 115_200,
    parameter logic [7:0]  SOF_BYTE     = SOF_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic [7:0]             frm_cmd_o,
    output logic [3:0]             frm_len_o,
    output logic [8*MAX_LEN-1:0]   frm_payload_o,
    output logic                   frm_valid_o,
    input  logic                   frm_ready_i,
    output logic                   err_chk_o,
    output logic                   err_len_o,
    output logic                   err_timeout_o,
    output logic                   err_overrun_o,
    output logic                   busy_o
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [15:0]            frm_count_o,
    output logic [15:0]            err_count_o
`endif
);

    localparam int unsigned CPB = calc_cpb(BASE_FREQ, BAUDRATE);

    frame_state_t         state_q;
    logic                 rx_valid_q;
    logic [7:0]           cmd_q;
    logic [3:0]           len_q;
    logic [3:0]           idx_q;
    logic [7:0]           chk_q;
    logic [8*MAX_LEN-1:0] payload_q;
    logic                 frm_valid_q;
    logic                 err_chk_q;
    logic                 err_len_q;
    logic                 err_timeout_q;
    logic                 err_overrun_q;

    logic byte_stb;
    logic tmo_run;
    logic tmo_expired;

    // rx_valid is a level; a byte is taken only on its rising edge.
    assign byte_stb = rx_valid_i && !rx_valid_q;
    assign tmo_run  = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    uart_frame_timeout #(
        .CPB          (CPB),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (byte_stb),
        .run_i     (tmo_run),
        .expired_o (tmo_expired)
    );

    // Frame sequencer with registered frame fields and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            rx_valid_q    <= 1'b1;
            cmd_q         <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            payload_q     <= '0;
            frm_valid_q   <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            rx_valid_q    <= rx_valid_i;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            if (tmo_expired) begin
                err_timeout_q <= 1'b1;
                state_q       <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (byte_stb && (rx_data_i == SOF_BYTE)) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_stb) begin
                            cmd_q   <= rx_data_i;
                            chk_q   <= rx_data_i;
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (byte_stb) begin
                            if (rx_data_i > 8'(MAX_LEN)) begin
                                err_len_q <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                len_q     <= rx_data_i[3:0];
                                chk_q     <= chk_q ^ rx_data_i;
                                idx_q     <= '0;
                                payload_q <= '0;
                                state_q   <= (rx_data_i == 8'd0) ? ST_CHK : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_stb) begin
                            payload_q[{idx_q, 3'b000} +: 8] <= rx_data_i;
                            chk_q <= chk_q ^ rx_data_i;
                            idx_q <= idx_q + 4'd1;
                            if (idx_q == len_q - 4'd1) begin
                                state_q <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (byte_stb) begin
                            if (rx_data_i == chk_q) begin
                                frm_valid_q <= 1'b1;
                                state_q     <= ST_HOLD;
                            end else begin
                                err_chk_q <= 1'b1;
                                state_q   <= ST_IDLE;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (frm_ready_i) begin
                            frm_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                        // A byte here is dropped, even when the frame is taken this cycle.
                        if (byte_stb) begin
                            err_overrun_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign frm_cmd_o     = cmd_q;
    assign frm_len_o     = len_q;
    assign frm_payload_o = payload_q;
    assign frm_valid_o   = frm_valid_q;
    assign err_chk_o     = err_chk_q;
    assign err_len_o     = err_len_q;
    assign err_timeout_o = err_timeout_q;
    assign err_overrun_o = err_overrun_q;
    assign busy_o        = (state_q != ST_IDLE);

`ifdef UART_FRAME_STATS_EN
    logic [15:0] frm_count_q;
    logic [15:0] err_count_q;

    // Saturating counters of accepted frames and error pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frm_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (frm_valid_q && frm_ready_i && (frm_count_q != 16'hFFFF)) begin
                frm_count_q <= frm_count_q + 16'd1;
            end
            if ((err_chk_q || err_len_q || err_timeout_q || err_overrun_q) &&
                (err_count_q != 16'hFFFF)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign frm_count_o = frm_count_q;
    assign err_count_o = err_count_q;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed scenarios plus a
// randomized byte stream checked against a queue-based frame model.
module tb_uart_frame_ctrl;

    localparam int         MAX_LEN  = 8;
    localparam logic [7:0] SOF      = 8'hA5;
    localparam int         TMO_CLKS = 434 * 40;

    localparam int EV_NONE  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_CHK   = 2;
    localparam int EV_LEN   = 3;
    localparam int EV_OVR   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [7:0]           rx_data = '0;
    logic                 rx_valid = 1'b0;
    logic                 frm_ready = 1'b0;
    logic [7:0]           frm_cmd;
    logic [3:0]           frm_len;
    logic [8*MAX_LEN-1:0] frm_payload;
    logic                 frm_valid;
    logic                 err_chk;
    logic                 err_len;
    logic                 err_timeout;
    logic                 err_overrun;
    logic                 busy;
`ifdef UART_FRAME_STATS_EN
    logic [15:0]          frm_count;
    logic [15:0]          err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frm_cnt = 0;
    int exp_err_cnt = 0;

    // reference model state
    logic [7:0]           m_q[$];
    logic                 m_active = 1'b0;
    logic                 m_hold = 1'b0;
    logic [7:0]           m_cmd;
    logic [3:0]           m_len;
    logic [8*MAX_LEN-1:0] m_pl;

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .BASE_FREQ    (50_000_000),
        .BAUDRATE     (115_200),
        .SOF_BYTE     (8'hA5),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .frm_cmd_o     (frm_cmd),
        .frm_len_o     (frm_len),
        .frm_payload_o (frm_payload),
        .frm_valid_o   (frm_valid),
        .frm_ready_i   (frm_ready),
        .err_chk_o     (err_chk),
        .err_len_o     (err_len),
        .err_timeout_o (err_timeout),
        .err_overrun_o (err_overrun),
        .busy_o        (busy)
`ifdef UART_FRAME_STATS_EN
        ,
        .frm_count_o   (frm_count),
        .err_count_o   (err_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte: rx_valid low for a cycle, then a rising edge with the data.
    // Returns one cycle after the strobing edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b0;
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] xor_chk(input logic [7:0] cmd, input logic [7:0] len,
                                           input logic [8*MAX_LEN-1:0] pl);
        logic [7:0] x;
        x = cmd ^ len;
        for (int i = 0; i < int'(len); i++) x = x ^ pl[8*i +: 8];
        return x;
    endfunction

    // Frame-level model: collects bytes after SOF and judges the frame once
    // LEN+3 bytes are in, or as soon as LEN is known to be too large.
    task automatic model_byte(input logic [7:0] b, output int ev);
        logic [7:0] x;
        int n;
        ev = EV_NONE;
        if (m_hold) begin
            ev = EV_OVR;
        end else if (!m_active) begin
            if (b == SOF) begin
                m_active = 1'b1;
                m_q.delete();
            end
        end else begin
            m_q.push_back(b);
            n = m_q.size();
            if (n == 2 && int'(m_q[1]) > MAX_LEN) begin
                ev = EV_LEN;
                m_active = 1'b0;
            end else if (n >= 2 && n == int'(m_q[1]) + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ m_q[i];
                if (x == m_q[n-1]) begin
                    ev = EV_FRAME;
                    m_hold = 1'b1;
                    m_cmd = m_q[0];
                    m_len = m_q[1][3:0];
                    m_pl = '0;
                    for (int i = 0; i < int'(m_q[1]); i++) m_pl[8*i +: 8] = m_q[2+i];
                end else begin
                    ev = EV_CHK;
                end
                m_active = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        frm_ready = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({busy, frm_valid, err_chk, err_len, err_timeout, err_overrun} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, frm_valid, err_chk, err_len, err_timeout, err_overrun});
        end
        n_cmp++;
        if ({frm_cmd, frm_len, frm_payload} !== '0) begin
            n_bad++;
            $display("FAIL reset_fields: got cmd=%h len=%h pl=%h want 0", frm_cmd, frm_len, frm_payload);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] fr[7];
        logic       seen_err;
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        fr[6] = xor_chk(8'h10, 8'h03, 64'h332211);
        frm_ready = 1'b1;
        seen_err = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_byte(fr[i]);
            seen_err = seen_err | err_chk | err_len | err_timeout | err_overrun;
        end
        n_cmp++;
        if (frm_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_valid: got %b want 1", frm_valid);
        end
        n_cmp++;
        if (frm_cmd !== 8'h10 || frm_len !== 4'd3 || frm_payload !== 64'h332211) begin
            n_bad++;
            $display("FAIL basic_fields: got cmd=%h len=%0d pl=%h want 10/3/332211",
                     frm_cmd, frm_len, frm_payload);
        end
        n_cmp++;
        if (seen_err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_noerr: got err seen=%b want 0", seen_err);
        end
        tick();
        exp_frm_cnt++;
        n_cmp++;
        if (frm_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_accept: got valid=%b busy=%b want 0/0", frm_valid, busy);
        end
    endtask

    task automatic test_chk_err();
        logic [7:0] fr[7];
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        frm_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_byte(fr[i]);
        exp_err_cnt++;
        n_cmp++;
        if (err_chk !== 1'b1 || frm_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_pulse: got err_chk=%b valid=%b want 1/0", err_chk, frm_valid);
        end
        tick();
        n_cmp++;
        if (err_chk !== 1'b0 || busy !== 1'b0 || frm_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_after: got err_chk=%b busy=%b valid=%b want 0/0/0", err_chk, busy, frm_valid);
        end
        fr[1] = 8'h44;
        fr[6] = xor_chk(8'h44, 8'h03, 64'h332211);
        for (int i = 0; i < 7; i++) send_byte(fr[i]);
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_cmd !== 8'h44 || frm_payload !== 64'h332211) begin
            n_bad++;
            $display("FAIL chk_recover: got valid=%b cmd=%h pl=%h want 1/44/332211",
                     frm_valid, frm_cmd, frm_payload);
        end
        tick();
        exp_frm_cnt++;
    endtask

    task automatic test_len();
        frm_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h09);
        exp_err_cnt++;
        n_cmp++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL len_err: got err_len=%b busy=%b want 1/0", err_len, busy);
        end
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h20);
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_len !== 4'd0 || frm_payload !== '0 || frm_cmd !== 8'h20) begin
            n_bad++;
            $display("FAIL len_zero: got valid=%b len=%0d pl=%h cmd=%h want 1/0/0/20",
                     frm_valid, frm_len, frm_payload, frm_cmd);
        end
        tick();
        exp_frm_cnt++;
    endtask

    task automatic test_timeout();
        logic early;
        frm_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h10);
        early = 1'b0;
        for (int i = 1; i < TMO_CLKS; i++) begin
            tick();
            early = early | err_timeout;
        end
        n_cmp++;
        if (early !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_early: got early=%b busy=%b want 0/1", early, busy);
        end
        tick();
        exp_err_cnt++;
        n_cmp++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_pulse: got err_timeout=%b busy=%b want 1/0", err_timeout, busy);
        end
        send_byte(8'hA5);
        send_byte(8'h10);
        early = 1'b0;
        for (int i = 0; i < 17000; i++) begin
            tick();
            early = early | err_timeout;
        end
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(xor_chk(8'h10, 8'h03, 64'h332211));
        n_cmp++;
        if (early !== 1'b0 || frm_valid !== 1'b1 || frm_payload !== 64'h332211) begin
            n_bad++;
            $display("FAIL tmo_gap: got tmo=%b valid=%b pl=%h want 0/1/332211", early, frm_valid, frm_payload);
        end
        tick();
        exp_frm_cnt++;
    endtask

    task automatic test_overrun();
        logic [7:0] ob[2];
        ob = '{8'h55, 8'hA5};
        frm_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(xor_chk(8'h10, 8'h03, 64'h332211));
        for (int i = 0; i < 2; i++) begin
            send_byte(ob[i]);
            exp_err_cnt++;
            n_cmp++;
            if (err_overrun !== 1'b1 || frm_valid !== 1'b1 || frm_cmd !== 8'h10 ||
                frm_len !== 4'd3 || frm_payload !== 64'h332211) begin
                n_bad++;
                $display("FAIL ovr_%0d: got ovr=%b valid=%b cmd=%h len=%0d pl=%h want 1/1/10/3/332211",
                         i, err_overrun, frm_valid, frm_cmd, frm_len, frm_payload);
            end
        end
        frm_ready = 1'b1;
        tick();
        exp_frm_cnt++;
        n_cmp++;
        if (frm_valid !== 1'b0 || busy !== 1'b0 || err_overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_accept: got valid=%b busy=%b ovr=%b want 0/0/0", frm_valid, busy, err_overrun);
        end
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h7E);
        send_byte(xor_chk(8'h30, 8'h01, 64'h7E));
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_cmd !== 8'h30 || frm_len !== 4'd1 || frm_payload !== 64'h7E) begin
            n_bad++;
            $display("FAIL ovr_next: got valid=%b cmd=%h len=%0d pl=%h want 1/30/1/7e",
                     frm_valid, frm_cmd, frm_len, frm_payload);
        end
        tick();
        exp_frm_cnt++;
        // ready and a new byte in the same cycle
        frm_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h31);
        send_byte(8'h00);
        send_byte(8'h31);
        rx_valid = 1'b0;
        tick();
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        frm_ready = 1'b1;
        tick();
        exp_frm_cnt++;
        exp_err_cnt++;
        n_cmp++;
        if (frm_valid !== 1'b0 || err_overrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_simul: got valid=%b ovr=%b busy=%b want 0/1/0", frm_valid, err_overrun, busy);
        end
        tick();
        tick();
`ifdef UART_FRAME_STATS_EN
        n_cmp++;
        if (frm_count !== 16'(exp_frm_cnt) || err_count !== 16'(exp_err_cnt)) begin
            n_bad++;
            $display("FAIL stats_dir: got frm=%0d err=%0d want %0d/%0d", frm_count, err_count,
                     exp_frm_cnt, exp_err_cnt);
        end
`endif
    endtask

    task automatic test_rst_cases();
        logic seen_err;
        frm_ready = 1'b1;
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_frm_cnt = 0;
        exp_err_cnt = 0;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_level: got busy=%b want 0", busy);
        end
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_midframe_busy: got busy=%b want 1", busy);
        end
        rst = 1'b1;
        tick();
        seen_err = err_chk | err_len | err_timeout | err_overrun;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: got busy=%b want 0", busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_err = seen_err | err_chk | err_len | err_timeout | err_overrun;
        end
        n_cmp++;
        if (seen_err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_noerr: got err=%b busy=%b want 0/0", seen_err, busy);
        end
        send_byte(8'hA5);
        send_byte(8'h66);
        send_byte(8'h02);
        send_byte(8'hA5);
        send_byte(8'h5A);
        send_byte(xor_chk(8'h66, 8'h02, 64'h5AA5));
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_cmd !== 8'h66 || frm_payload !== 64'h5AA5) begin
            n_bad++;
            $display("FAIL rst_recover: got valid=%b cmd=%h pl=%h want 1/66/5aa5", frm_valid, frm_cmd, frm_payload);
        end
        tick();
        exp_frm_cnt++;
    endtask

    task automatic test_random();
        logic [7:0]           bq[$];
        logic [7:0]           cmd;
        logic [7:0]           len;
        logic [8*MAX_LEN-1:0] pl;
        logic [7:0]           chk;
        int                   kind;
        int                   ev;
        frm_ready = 1'b0;
        m_q.delete();
        m_active = 1'b0;
        m_hold = 1'b0;
        for (int it = 0; it < 60; it++) begin
            bq.delete();
            kind = int'($urandom_range(0, 9));
            if (kind == 0) bq.push_back(8'($urandom_range(0, 255)));
            cmd = 8'($urandom_range(0, 255));
            len = (kind == 1) ? 8'($urandom_range(MAX_LEN + 1, 15)) : 8'($urandom_range(0, MAX_LEN));
            pl = '0;
            for (int i = 0; i < MAX_LEN; i++) if (i < int'(len)) pl[8*i +: 8] = 8'($urandom_range(0, 255));
            chk = xor_chk(cmd, (len > 8'(MAX_LEN)) ? 8'd0 : len, pl) ^ ((len > 8'(MAX_LEN)) ? len : 8'd0);
            if (kind == 2) chk = chk ^ 8'($urandom_range(1, 255));
            bq.push_back(SOF);
            bq.push_back(cmd);
            bq.push_back(len);
            for (int i = 0; i < MAX_LEN; i++) if (i < int'(len)) bq.push_back(pl[8*i +: 8]);
            bq.push_back(chk);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) bq.push_back(8'($urandom_range(0, 255)));
            foreach (bq[k]) begin
                model_byte(bq[k], ev);
                send_byte(bq[k]);
                if (ev != EV_NONE && ev != EV_FRAME) exp_err_cnt++;
                n_cmp++;
                if (err_chk !== (ev == EV_CHK) || err_len !== (ev == EV_LEN) ||
                    err_overrun !== (ev == EV_OVR) || err_timeout !== 1'b0 || frm_valid !== m_hold) begin
                    n_bad++;
                    $display("FAIL rnd_flags it%0d b%0d: got chk=%b len=%b ovr=%b tmo=%b valid=%b want ev=%0d valid=%b",
                             it, k, err_chk, err_len, err_overrun, err_timeout, frm_valid, ev, m_hold);
                end
                if (ev == EV_FRAME) begin
                    n_cmp++;
                    if (frm_cmd !== m_cmd || frm_len !== m_len || frm_payload !== m_pl) begin
                        n_bad++;
                        $display("FAIL rnd_fields it%0d: got cmd=%h len=%0d pl=%h want %h/%0d/%h",
                                 it, frm_cmd, frm_len, frm_payload, m_cmd, m_len, m_pl);
                    end
                end
            end
            if (m_hold) begin
                frm_ready = 1'b1;
                tick();
                frm_ready = 1'b0;
                m_hold = 1'b0;
                exp_frm_cnt++;
                n_cmp++;
                if (frm_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rnd_accept it%0d: got valid=%b want 0", it, frm_valid);
                end
            end
        end
        repeat (3) tick();
`ifdef UART_FRAME_STATS_EN
        n_cmp++;
        if (frm_count !== 16'(exp_frm_cnt) || err_count !== 16'(exp_err_cnt)) begin
            n_bad++;
            $display("FAIL stats_rnd: got frm=%0d err=%0d want %0d/%0d", frm_count, err_count,
                     exp_frm_cnt, exp_err_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chk_err();
        test_len();
        test_timeout();
        test_overrun();
        test_rst_cases();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
